// File: rtl/calc_pkg.sv
// Shared calculator definitions: the serial-subtractor state type and default datapath width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

    // Default operand/result width for calculator datapath blocks.
    localparam int CALC_WIDTH = 8;

    // Serial subtractor control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } calc_state_t;

endpackage

// File: rtl/one_bit_subtractor.sv
// Combinational full-subtractor cell: Diff = A - B - Bin (one bit), Bout = borrow out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: A, B, Bin (inputs); Diff, Bout (outputs).
module one_bit_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B ^ Bin;
    // Borrow when B exceeds A outright, or when they are equal and a borrow ripples in.
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: (A - B - Borrow_in) mod 2^N, one bit per clock through a single cell.
// Latency: done pulses N cycles after the accepted start edge; one operation per N+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, never queued.
// Ports: clk, rst (async, active-high); start, A, B, Borrow_in (request);
//        busy, done, Diff, Borrow_out, Overflow, Zero (registered status and results).
module serial_subtractor
    import calc_pkg::*;
#(
    parameter int N = CALC_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Borrow_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Diff,
    output logic         Borrow_out,
    output logic         Overflow,
    output logic         Zero
);

    // Counter only has to reach N-1; the last-bit compare is exact, so no aliasing for any N >= 2.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    calc_state_t   state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  res_sh;
    logic          bw;
    logic          a_msb;
    logic          b_msb;
    logic [CW-1:0] cnt;

    logic          d_bit;
    logic          bw_next;
    logic [N-1:0]  diff_fin;

    one_bit_subtractor u_cell (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Bin  (bw),
        .Diff (d_bit),
        .Bout (bw_next)
    );

    // Result register after this cycle's bit is shifted in; on the last bit it is the full difference.
    assign diff_fin = {d_bit, res_sh[N-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            bw         <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            Diff       <= '0;
            Borrow_out <= 1'b0;
            Overflow   <= 1'b0;
            Zero       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        bw    <= Borrow_in;
                        // Sign bits are shifted out during RUN, so keep them for the overflow flag.
                        a_msb <= A[N-1];
                        b_msb <= B[N-1];
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    bw     <= bw_next;
                    res_sh <= diff_fin;
                    if (cnt == LAST_BIT) begin
                        cnt        <= '0;
                        state      <= DONE;
                        done       <= 1'b1;
                        Diff       <= diff_fin;
                        Borrow_out <= bw_next;
                        // d_bit is the result MSB on the final bit.
                        Overflow   <= (a_msb != b_msb) && (d_bit != a_msb);
                        Zero       <= ~|diff_fin;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
